// File: rtl/icache_pkg.sv
// Shared types, constants and width helpers for the instruction cache.
package icache_pkg;

    // Controller states; LOOKUP is the reset state.
    typedef enum logic [1:0] {
        LOOKUP = 2'd0,
        REQ    = 2'd1,
        FILL   = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Canonical RISC-V nop (addi x0, x0, 0).
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    // Byte-offset width of a line: word select bits plus the two byte bits.
    function automatic int off_w(input int words_per_line);
        return $clog2(words_per_line) + 2;
    endfunction

    // Index width for a given number of lines.
    function automatic int idx_w(input int lines);
        return $clog2(lines);
    endfunction

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/icache_data_ram.sv
// Single-port synchronous RAM: write has priority, read data is registered.
module icache_data_ram #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic             i_re,
    input  logic [AW-1:0]    i_addr,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // One access per cycle; the read register holds its value when idle.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache with single-cycle hits and line refill.
// Handshakes: a fetch is accepted on any rising edge where i_req && o_ready;
// o_valid marks o_data for the oldest accepted fetch for exactly one cycle;
// o_mem_req holds with a stable o_mem_addr until sampled with i_mem_gnt, after
// which each cycle with i_mem_valid carries the next beat of the line.
module icache
    import icache_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int LINES          = 64,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_ready,
    output logic              o_valid,
    output logic [31:0]       o_data,
    input  logic              i_flush,
    output logic              o_mem_req,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic              i_mem_gnt,
    input  logic              i_mem_valid,
    input  logic [31:0]       i_mem_data,
    output state_t            o_dbg_state
);
    localparam int OFF_W  = off_w(WORDS_PER_LINE);
    localparam int WSEL_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W  = idx_w(LINES);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int RAM_AW = IDX_W + WSEL_W;

    if (DATA_W != 32) begin : g_bad_data_w
        $error("icache: DATA_W must be 32");
    end
    if (!is_pow2(LINES) || LINES < 2) begin : g_bad_lines
        $error("icache: LINES must be a power of two >= 2");
    end
    if (!is_pow2(WORDS_PER_LINE) || WORDS_PER_LINE < 2) begin : g_bad_wpl
        $error("icache: WORDS_PER_LINE must be a power of two >= 2");
    end
    if (TAG_W < 1) begin : g_bad_addr_w
        $error("icache: ADDR_W too small for the chosen geometry");
    end

    state_t              r_state, w_next;
    logic                r_alive;
    logic [LINES-1:0]    r_valid;
    logic [TAG_W-1:0]    r_tags [LINES];
    logic                r_cmp_pend;
    logic [IDX_W-1:0]    r_cmp_idx, r_idx;
    logic [TAG_W-1:0]    r_cmp_tag, r_tag;
    logic [WSEL_W-1:0]   r_cmp_word, r_word, r_beat;
    logic                r_flush_pend;
    logic [31:0]         r_resp_data;
    logic [TAG_W-1:0]    w_addr_tag;
    logic [IDX_W-1:0]    w_addr_idx;
    logic [WSEL_W-1:0]   w_addr_word;
    logic                w_hit, w_miss, w_accept, w_beat, w_last_beat;
    logic [RAM_AW-1:0]   w_ram_addr;
    logic [31:0]         w_rdata;
    logic                w_unused;

    assign w_addr_tag  = i_addr[ADDR_W-1 -: TAG_W];
    assign w_addr_idx  = i_addr[OFF_W +: IDX_W];
    assign w_addr_word = i_addr[2 +: WSEL_W];
    assign w_unused    = ^i_addr[1:0];

    // The compare stage looks at the fetch accepted on the previous edge.
    assign w_hit       = r_cmp_pend && r_valid[r_cmp_idx] && (r_tags[r_cmp_idx] == r_cmp_tag);
    assign w_miss      = r_cmp_pend && !w_hit;
    assign w_accept    = i_req && o_ready;
    assign w_beat      = (r_state == FILL) && i_mem_valid;
    assign w_last_beat = w_beat && (r_beat == WSEL_W'(WORDS_PER_LINE - 1));
    assign w_ram_addr  = (r_state == FILL) ? {r_idx, r_beat} : {w_addr_idx, w_addr_word};
    assign o_mem_addr  = {r_tag, r_idx, {OFF_W{1'b0}}};
    assign o_dbg_state = r_state;

    icache_data_ram #(
        .DEPTH (LINES * WORDS_PER_LINE),
        .WIDTH (32),
        .AW    (RAM_AW)
    ) u_data_ram (
        .i_clk   (i_clk),
        .i_we    (w_beat),
        .i_re    (w_accept),
        .i_addr  (w_ram_addr),
        .i_wdata (i_mem_data),
        .o_rdata (w_rdata)
    );

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= LOOKUP;
        else          r_state <= w_next;
    end

    // Next-state: a miss starts a refill that always ends with one response.
    always_comb begin
        w_next = r_state;
        case (r_state)
            LOOKUP:  if (w_miss) w_next = REQ;
            REQ:     if (i_mem_gnt) w_next = FILL;
            FILL:    if (w_last_beat) w_next = RESP;
            RESP:    w_next = LOOKUP;
            default: w_next = LOOKUP;
        endcase
    end

    // Outputs: hits answer from the RAM read port, refills from the captured beat.
    always_comb begin
        o_ready   = 1'b0;
        o_valid   = 1'b0;
        o_data    = '0;
        o_mem_req = 1'b0;
        case (r_state)
            LOOKUP: begin
                o_ready = r_alive && !w_miss;
                o_valid = w_hit;
                o_data  = w_hit ? w_rdata : '0;
            end
            REQ:     o_mem_req = 1'b1;
            RESP: begin
                o_valid = 1'b1;
                o_data  = r_resp_data;
            end
            default: ;
        endcase
    end

    // Compare pipeline, refill bookkeeping, valid bits and flush tracking.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_alive      <= 1'b0;
            r_valid      <= '0;
            r_cmp_pend   <= 1'b0;
            r_cmp_idx    <= '0;
            r_cmp_tag    <= '0;
            r_cmp_word   <= '0;
            r_idx        <= '0;
            r_tag        <= '0;
            r_word       <= '0;
            r_beat       <= '0;
            r_flush_pend <= 1'b0;
            r_resp_data  <= '0;
        end else begin
            r_alive    <= 1'b1;
            r_cmp_pend <= w_accept;
            if (w_accept) begin
                r_cmp_idx  <= w_addr_idx;
                r_cmp_tag  <= w_addr_tag;
                r_cmp_word <= w_addr_word;
            end
            if ((r_state == LOOKUP) && w_miss) begin
                r_idx  <= r_cmp_idx;
                r_tag  <= r_cmp_tag;
                r_word <= r_cmp_word;
            end
            if (w_beat) begin
                r_beat <= r_beat + 1'b1;
                if (r_beat == r_word) r_resp_data <= i_mem_data;
            end
            // A flush seen at any point of a refill keeps that line invalid.
            if (i_flush) begin
                r_valid <= '0;
            end else if (w_last_beat && !r_flush_pend) begin
                r_valid[r_idx] <= 1'b1;
            end
            if (r_state == RESP) begin
                r_flush_pend <= 1'b0;
            end else if ((r_state != LOOKUP) && i_flush) begin
                r_flush_pend <= 1'b1;
            end
        end
    end

    // Tags need no reset: a line is only trusted through its valid bit.
    always_ff @(posedge i_clk) begin
        if (w_last_beat) r_tags[r_idx] <= r_tag;
    end
endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios plus a randomized mix,
// checked against a line-level model of what the cache should hold.
module tb_icache;
    import icache_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic        o_ready;
    logic        o_valid;
    logic [31:0] o_data;
    logic        i_flush;
    logic        o_mem_req;
    logic [31:0] o_mem_addr;
    logic        i_mem_gnt;
    logic        i_mem_valid;
    logic [31:0] i_mem_data;
    state_t      o_dbg_state;

    int checks = 0;
    int errors = 0;

    icache #(
        .ADDR_W(32), .DATA_W(32), .LINES(64), .WORDS_PER_LINE(4)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_addr(i_addr),
        .o_ready(o_ready), .o_valid(o_valid), .o_data(o_data), .i_flush(i_flush),
        .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr), .i_mem_gnt(i_mem_gnt),
        .i_mem_valid(i_mem_valid), .i_mem_data(i_mem_data), .o_dbg_state(o_dbg_state)
    );

    // ---------------- clock ----------------
    always #5 i_clk = ~i_clk;

    // ---------------- main memory model ----------------
    int mem_gen = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a, input int gen);
        if (a[31:4] == 28'h10 && gen == 0) return 32'hA0 + 32'(a[3:2]);
        return (a * 32'h9E37_79B1) ^ 32'(gen);
    endfunction

    // ---------------- cache reference model (whole lines) ----------------
    bit          model_has  [64];
    logic [27:0] model_line [64];
    int          model_gen  [64];

    function automatic void model_clear();
        for (int i = 0; i < 64; i++) model_has[i] = 1'b0;
    endfunction

    function automatic void model_lookup(input logic [31:0] a, output bit hit, output logic [31:0] data);
        int idx;
        idx  = int'(a[9:4]);
        hit  = model_has[idx] && (model_line[idx] == a[31:4]);
        data = mem_word({a[31:2], 2'b00}, hit ? model_gen[idx] : mem_gen);
    endfunction

    // ---------------- memory responder ----------------
    int          rsp_wait_cfg = 0;
    int          rsp_gap_mode = 0;
    int          rsp_phase = 0;
    int          rsp_cnt = 0;
    int          rsp_beats = 0;
    int          rsp_fill_cycles = 0;
    int          rsp_last_wait = 0;
    int          rsp_last_fill = 0;
    int          refill_cnt = 0;
    bit          rsp_tog = 1'b0;
    logic [31:0] rsp_addr = '0;

    initial begin
        bit drive;
        i_mem_gnt = 1'b0; i_mem_valid = 1'b0; i_mem_data = '0;
        forever begin
            @(negedge i_clk);
            i_mem_gnt   = 1'b0;
            i_mem_valid = 1'b0;
            i_mem_data  = $urandom;
            if (!i_rst_n) begin
                rsp_phase = 0;
                continue;
            end
            if (rsp_phase == 0) begin
                if (o_mem_req === 1'b1) begin
                    rsp_addr  = o_mem_addr;
                    refill_cnt++;
                    rsp_cnt   = 0;
                    rsp_phase = 1;
                end else begin
                    // Stray beats outside a refill must be ignored.
                    i_mem_valid = 1'($urandom_range(0, 1));
                end
            end
            if (rsp_phase == 1) begin
                checks++;
                if (o_mem_req !== 1'b1 || o_mem_addr !== rsp_addr)
                    $display("FAIL mem_req_stable: req=%b addr=%h, required req=1 addr=%h", o_mem_req, o_mem_addr, rsp_addr);
                if (o_mem_req !== 1'b1 || o_mem_addr !== rsp_addr) errors++;
                i_mem_valid = 1'($urandom_range(0, 1));
                if (rsp_cnt == rsp_wait_cfg) begin
                    i_mem_gnt       = 1'b1;
                    rsp_phase       = 2;
                    rsp_beats       = 0;
                    rsp_fill_cycles = 0;
                    rsp_tog         = 1'b0;
                    rsp_last_wait   = rsp_wait_cfg;
                end else begin
                    rsp_cnt++;
                end
            end else if (rsp_phase == 2) begin
                rsp_fill_cycles++;
                case (rsp_gap_mode)
                    0:       drive = 1'b1;
                    1:       drive = !rsp_tog;
                    default: drive = 1'($urandom_range(0, 1));
                endcase
                rsp_tog = !rsp_tog;
                if (drive) begin
                    i_mem_valid = 1'b1;
                    i_mem_data  = mem_word(rsp_addr + 32'(4 * rsp_beats), mem_gen);
                    rsp_beats++;
                    if (rsp_beats == 4) begin
                        rsp_phase     = 0;
                        rsp_last_fill = rsp_fill_cycles;
                    end
                end
            end
        end
    end

    // ---------------- driver: one fetch, fully checked ----------------
    task automatic fetch(input logic [31:0] addr, input bit flush_with, input bit flush_mid, input string nm);
        bit          exp_hit, got, flushed;
        logic [31:0] exp_data;
        int          base, lat, exp_lat, idx;
        model_lookup(addr, exp_hit, exp_data);
        if (flush_with) begin
            exp_hit  = 1'b0;
            exp_data = mem_word({addr[31:2], 2'b00}, mem_gen);
            model_clear();
        end
        base = refill_cnt;
        @(negedge i_clk);
        i_req = 1'b1; i_addr = addr; i_flush = flush_with;
        lat = 0;
        while (o_ready !== 1'b1 && lat < 50) begin
            @(negedge i_clk); lat++;
        end
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready: got %b required 1", nm, o_ready);
        end
        @(negedge i_clk);
        i_req = 1'b0; i_flush = 1'b0; i_addr = $urandom;
        lat = 1; got = 1'b0; flushed = 1'b0;
        while (lat < 200) begin
            if (o_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
            if (flush_mid && !flushed && rsp_phase == 2) begin
                i_flush = 1'b1; flushed = 1'b1;
            end else begin
                i_flush = 1'b0;
            end
            @(negedge i_clk); lat++;
        end
        i_flush = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s timeout: no o_valid within %0d cycles", nm, lat);
        end
        checks++;
        if (o_data !== exp_data) begin
            errors++;
            $display("FAIL %s data: got %h required %h", nm, o_data, exp_data);
        end
        checks++;
        if (refill_cnt - base != (exp_hit ? 0 : 1)) begin
            errors++;
            $display("FAIL %s refills: got %0d required %0d", nm, refill_cnt - base, exp_hit ? 0 : 1);
        end
        exp_lat = exp_hit ? 1 : 3 + rsp_last_wait + rsp_last_fill;
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d required %0d", nm, lat, exp_lat);
        end
        if (!exp_hit) begin
            checks++;
            if (rsp_addr !== {addr[31:4], 4'h0}) begin
                errors++;
                $display("FAIL %s mem_addr: got %h required %h", nm, rsp_addr, {addr[31:4], 4'h0});
            end
        end
        @(negedge i_clk);
        checks++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s single_valid: got %b required 0", nm, o_valid);
        end
        idx = int'(addr[9:4]);
        if (flushed) begin
            model_clear();
        end else if (!exp_hit) begin
            model_has[idx]  = 1'b1;
            model_line[idx] = addr[31:4];
            model_gen[idx]  = mem_gen;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        i_rst_n = 1'b0; i_req = 1'b0; i_addr = '0; i_flush = 1'b0;
        model_clear();
        repeat (3) @(negedge i_clk);
        checks++; if (o_ready !== 1'b0)          begin errors++; $display("FAIL rst_ready: got %b required 0", o_ready); end
        checks++; if (o_valid !== 1'b0)          begin errors++; $display("FAIL rst_valid: got %b required 0", o_valid); end
        checks++; if (o_data !== 32'h0)          begin errors++; $display("FAIL rst_data: got %h required 0", o_data); end
        checks++; if (o_mem_req !== 1'b0)        begin errors++; $display("FAIL rst_mem_req: got %b required 0", o_mem_req); end
        checks++; if (o_mem_addr !== 32'h0)      begin errors++; $display("FAIL rst_mem_addr: got %h required 0", o_mem_addr); end
        checks++; if (o_dbg_state !== LOOKUP)    begin errors++; $display("FAIL rst_state: got %0d required %0d", o_dbg_state, LOOKUP); end
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);
        checks++; if (o_ready !== 1'b1)          begin errors++; $display("FAIL post_rst_ready: got %b required 1", o_ready); end
    endtask

    task automatic test_cold_miss();
        rsp_wait_cfg = 3; rsp_gap_mode = 0;
        fetch(32'h104, 1'b0, 1'b0, "cold_miss");
        checks++;
        if (rsp_last_wait + rsp_last_fill + 3 != 10) begin
            errors++;
            $display("FAIL cold_miss_budget: got %0d required 10", rsp_last_wait + rsp_last_fill + 3);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a [4];
        logic [31:0] e [4];
        bit          h;
        int          base;
        for (int i = 0; i < 4; i++) begin
            a[i] = 32'h100 + 32'(4 * i);
            model_lookup(a[i], h, e[i]);
        end
        base = refill_cnt;
        for (int i = 0; i <= 4; i++) begin
            @(negedge i_clk);
            if (i > 0) begin
                checks++;
                if (o_valid !== 1'b1 || o_data !== e[i-1]) begin
                    errors++;
                    $display("FAIL b2b_word%0d: got valid=%b data=%h required valid=1 data=%h", i - 1, o_valid, o_data, e[i-1]);
                end
            end
            if (i < 4) begin
                checks++;
                if (o_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_ready%0d: got %b required 1", i, o_ready);
                end
                i_req = 1'b1; i_addr = a[i];
            end else begin
                i_req = 1'b0;
            end
        end
        @(negedge i_clk);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL b2b_tail: got valid=%b required 0", o_valid); end
        checks++; if (refill_cnt != base) begin errors++; $display("FAIL b2b_refills: got %0d required 0", refill_cnt - base); end
    endtask

    task automatic test_conflict();
        rsp_wait_cfg = 1; rsp_gap_mode = 0;
        fetch(32'h100 + 32'(64 * 16), 1'b0, 1'b0, "conflict_new_tag");
        fetch(32'h100, 1'b0, 1'b0, "conflict_old_tag");
    endtask

    task automatic test_flush();
        rsp_wait_cfg = 0; rsp_gap_mode = 0;
        fetch(32'h100, 1'b0, 1'b0, "flush_pre_hit");
        @(negedge i_clk); i_flush = 1'b1;
        @(negedge i_clk); i_flush = 1'b0;
        model_clear();
        fetch(32'h100, 1'b0, 1'b0, "flush_after_pulse");
        fetch(32'h108, 1'b1, 1'b0, "flush_same_cycle");
        rsp_wait_cfg = 2;
        fetch(32'h300, 1'b0, 1'b1, "flush_in_fill");
        fetch(32'h304, 1'b0, 1'b0, "flush_in_fill_refetch");
    endtask

    task automatic test_gapped_beats();
        rsp_wait_cfg = 1; rsp_gap_mode = 1;
        fetch(32'h208, 1'b0, 1'b0, "gap_miss");
        checks++;
        if (rsp_last_fill != 7) begin
            errors++;
            $display("FAIL gap_fill_cycles: got %0d required 7", rsp_last_fill);
        end
        rsp_gap_mode = 0;
        for (int w = 0; w < 4; w++) fetch(32'h200 + 32'(4 * w), 1'b0, 1'b0, "gap_word_order");
    endtask

    task automatic test_reset_mid_fill();
        int n;
        rsp_wait_cfg = 1; rsp_gap_mode = 0;
        @(negedge i_clk);
        i_req = 1'b1; i_addr = 32'h400;
        @(negedge i_clk);
        i_req = 1'b0;
        n = 0;
        @(posedge i_clk);
        while (!(rsp_phase == 2 && rsp_beats >= 2) && n < 50) begin
            @(posedge i_clk); n++;
        end
        #1 i_rst_n = 1'b0;
        #1;
        checks++;
        if (o_ready !== 1'b0 || o_valid !== 1'b0 || o_data !== 32'h0 || o_mem_req !== 1'b0 ||
            o_mem_addr !== 32'h0 || o_dbg_state !== LOOKUP) begin
            errors++;
            $display("FAIL mid_fill_reset: got ready=%b valid=%b data=%h req=%b addr=%h state=%0d required all zero",
                     o_ready, o_valid, o_data, o_mem_req, o_mem_addr, o_dbg_state);
        end
        model_clear();
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);
        checks++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_fill_no_resp: got valid=%b required 0", o_valid);
        end
        fetch(32'h404, 1'b0, 1'b0, "mid_fill_refetch");
    endtask

    task automatic test_random();
        logic [27:0] lines [8];
        logic [31:0] a;
        lines = '{28'h10, 28'h11, 28'h50, 28'h51, 28'h12, 28'h90, 28'h52, 28'h13};
        for (int k = 0; k < 40; k++) begin
            rsp_wait_cfg = $urandom_range(0, 3);
            rsp_gap_mode = $urandom_range(0, 2);
            if ($urandom_range(0, 5) == 0) mem_gen++;
            a = {lines[$urandom_range(0, 7)], 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            fetch(a, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, "random");
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_cold_miss();
        test_back_to_back();
        test_conflict();
        test_flush();
        test_gapped_beats();
        test_reset_mid_fill();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation did not complete");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/icache.md
# icache

Parametrised direct-mapped instruction cache: the successor to the fixed 1024-word instruction memory at the fetch stage. It serves word reads to the IF stage with single-cycle hit latency. On a miss it refills a whole line from main memory over a request/grant plus beat handshake. It also supports a whole-cache flush, which `fence.i` will use.

## Interface
Parameters:
- `ADDR_W`, 32: byte address width.
- `DATA_W`, 32: instruction word width; fixed at 32, elaboration error otherwise.
- `LINES`, 64: number of lines; power of two, ≥2.
- `WORDS_PER_LINE`, 4: words per line; power of two, ≥2.

Ports:
- `i_clk`, in, 1: clock; all state updates on the rising edge.
- `i_rst_n`, in, 1: asynchronous active-low reset.
- `i_req`, in, 1: fetch request.
- `i_addr`, in, ADDR_W: fetch byte address; bits [1:0] ignored.
- `o_ready`, out, 1: request accepted this cycle when `i_req && o_ready`.
- `o_valid`, out, 1: `o_data` valid for the oldest accepted request.
- `o_data`, out, 32: instruction word.
- `i_flush`, in, 1: one-cycle pulse; invalidates all lines.
- `o_mem_req`, out, 1: line refill request.
- `o_mem_addr`, out, ADDR_W: line-aligned byte address; offset bits are zero.
- `i_mem_gnt`, in, 1: memory accepts the request.
- `i_mem_valid`, in, 1: one refill beat present.
- `i_mem_data`, in, 32: refill beat data, delivered in word order 0..WORDS_PER_LINE-1.

## Operation
- Address split:
  - OFF_W = log2(WORDS_PER_LINE) + 2.
  - IDX_W = log2(LINES).
  - TAG_W = ADDR_W − IDX_W − OFF_W.
  - Word select is `i_addr[OFF_W-1:2]`.
- Storage: data array LINES×WORDS_PER_LINE×32, tag array LINES×TAG_W, valid vector LINES.
- FSM states:
  - LOOKUP (reset state): `o_ready`=1 unless the pending compare misses. On hit, stay.
  - Miss → REQ: latch index, tag and word. `o_mem_req`=1 and `o_mem_addr` stable until `i_mem_gnt`.
  - REQ on `i_mem_gnt` → FILL.
  - FILL: count beats on `i_mem_valid` (counter wraps at WORDS_PER_LINE). Write each beat to the data array. On the last beat, write the tag; set valid unless a flush is pending. → RESP.
  - RESP: `o_valid`=1 with the requested word, taken from the captured beat and not re-read. → LOOKUP.
- `o_ready`=0 in REQ, FILL and RESP, and in the LOOKUP compare cycle that misses.
- Flush:
  - In LOOKUP, `i_flush` clears all valid bits at the next edge. A request accepted in the same cycle as `i_flush` is treated as a miss.
  - During REQ/FILL/RESP, a flush sets a pending flag. The refill completes and still returns data, but the line is left invalid. The pending flag clears on return to LOOKUP.
- No outstanding-request queue: at most one request in flight beyond the compare stage.

## Timing
- Hit: accepted at edge N → `o_valid`=1 during cycle N+1, from synchronous array read plus combinational tag compare. Back-to-back hits sustain one per cycle.
- Miss: `o_valid`=0 in N+1. `o_mem_req` rises at N+2. Data returns one cycle after the last beat.
- Total miss latency = 2 + gnt wait + WORDS_PER_LINE beats (gaps allowed) + 1.
- `i_mem_valid` before grant, or in LOOKUP/RESP, is ignored.
- Reset values:
  - `o_ready`=0 during reset, 1 after.
  - `o_valid`=0, `o_data`=0, `o_mem_req`=0, `o_mem_addr`=0.
  - FSM = LOOKUP, all valid bits 0, beat counter 0, flush-pending 0.
- Reset mid-refill abandons the refill. The line stays invalid and no response is produced.

## Structure
- Package `icache_pkg`:
  - state enum (LOOKUP, REQ, FILL, RESP).
  - `clog2`-based width helper functions.
  - the 32-bit NOP constant 0x00000013.
- Sub-module `icache_data_ram`: single-port synchronous RAM, parametrised depth/width, one write port for refill and one registered read. It is instantiated for the data array. Tags live in flops in the parent.

## Test plan
- Cold miss: `i_addr`=0x104, memory grants after 3 cycles and returns 0xA0..0xA3 for line 0x100 → `o_mem_addr`=0x100, `o_data`=0xA1, latency 2+3+4+1 cycles.
- Hit stream: after the fill, request 0x100, 0x104, 0x108, 0x10C on consecutive cycles → 4 consecutive `o_valid` with 0xA0..0xA3, no `o_mem_req`.
- Conflict: request 0x100 + LINES×16 (same index, new tag) → refill. A subsequent request to 0x100 misses again.
- Flush: hit 0x100, pulse `i_flush`, request 0x100 → miss and `o_mem_req`. Flush during FILL → data returned, next access to the same line misses.
- Gapped beats: `i_mem_valid` toggles 1,0,1,0… → correct word order in the array, response after the fourth valid beat.
- Reset mid-FILL after 2 beats: assert `i_rst_n`=0 → outputs at reset values immediately. After release, request to the same line → miss.
